fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem request, IF/ID register and one-entry skid buffer.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds the if_id_misaligned output and blocks misaligned fetches.
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_en,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  stall_in,
  input  logic                  flush_in,
  output logic                  if_id_valid,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                  if_id_misaligned,
`endif
  output logic [DATA_WIDTH-1:0] if_id_instr
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_q_reg;
  logic                    skid_valid_reg;
  logic [ADDR_WIDTH-1:0]   skid_pc_reg;
  logic [DATA_WIDTH-1:0]   skid_instr_reg;
  logic                    if_id_valid_reg;
  logic [ADDR_WIDTH-1:0]   if_id_pc_reg;
  logic [DATA_WIDTH-1:0]   if_id_instr_reg;

  logic req_valid_c;
  logic req_fire;
  logic rsp_fresh;
  logic if_id_hold;
  logic fetch_block;
  logic misalign_load;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_stuck_reg;
  logic if_id_mis_reg;
  logic pc_misaligned;

  assign pc_misaligned = (pc_in[1:0] != 2'b00);
  assign fetch_block   = pc_misaligned || misalign_stuck_reg;
  // Misaligned PC turns into a poisoned IF/ID entry instead of a memory read
  assign misalign_load = (state_reg == ST_REQ) && pc_misaligned && !misalign_stuck_reg &&
                         !skid_valid_reg;
`else
  assign fetch_block   = 1'b0;
  assign misalign_load = 1'b0;
`endif

  assign if_id_hold  = stall_in && if_id_valid_reg;
  assign req_valid_c = (state_reg == ST_REQ) && !rst && !skid_valid_reg && !flush_in && !fetch_block;
  assign req_fire    = req_valid_c && imem_req_ready;
  assign rsp_fresh   = (state_reg == ST_WAIT) && imem_rsp_valid && !flush_in;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_REQ: begin
        if (req_fire) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid)  state_next = ST_REQ;
        else if (flush_in)   state_next = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rsp_valid) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req_valid = req_valid_c;
    imem_req_addr  = pc_in;
    pc_en          = req_fire;
  end

  // IF/ID register and skid buffer; a skid entry always drains before any fresh word
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q_reg        <= '0;
      skid_valid_reg  <= 1'b0;
      skid_pc_reg     <= '0;
      skid_instr_reg  <= '0;
      if_id_valid_reg <= 1'b0;
      if_id_pc_reg    <= '0;
      if_id_instr_reg <= '0;
    end else begin
      if (req_fire) pc_q_reg <= pc_in;

      if (flush_in) begin
        if_id_valid_reg <= 1'b0;
        skid_valid_reg  <= 1'b0;
      end else if (if_id_hold) begin
        if (rsp_fresh) begin
          skid_valid_reg <= 1'b1;
          skid_pc_reg    <= pc_q_reg;
          skid_instr_reg <= imem_rsp_data;
        end
      end else if (skid_valid_reg) begin
        if_id_valid_reg <= 1'b1;
        if_id_pc_reg    <= skid_pc_reg;
        if_id_instr_reg <= skid_instr_reg;
        skid_valid_reg  <= 1'b0;
      end else if (rsp_fresh) begin
        if_id_valid_reg <= 1'b1;
        if_id_pc_reg    <= pc_q_reg;
        if_id_instr_reg <= imem_rsp_data;
      end else if (misalign_load) begin
        if_id_valid_reg <= 1'b1;
        if_id_pc_reg    <= pc_in;
        if_id_instr_reg <= '0;
      end else begin
        if_id_valid_reg <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Tracks the poison flag alongside IF/ID; fetch stays frozen until a redirect
  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      misalign_stuck_reg <= 1'b0;
      if_id_mis_reg      <= 1'b0;
    end else if (if_id_hold) begin
      if_id_mis_reg <= if_id_mis_reg;
    end else if (skid_valid_reg || rsp_fresh) begin
      if_id_mis_reg <= 1'b0;
    end else if (misalign_load) begin
      if_id_mis_reg      <= 1'b1;
      misalign_stuck_reg <= 1'b1;
    end else begin
      if_id_mis_reg <= 1'b0;
    end
  end

  assign if_id_misaligned = if_id_mis_reg;
`endif

  assign if_id_valid = if_id_valid_reg;
  assign if_id_pc    = if_id_pc_reg;
  assign if_id_instr = if_id_instr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected IF/ID entries, immediate-assertion checks.
// Define FETCH_MISALIGN_CHECK_EN to also exercise the misaligned-PC path.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_in;
  logic        flush_in;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        if_id_misaligned;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_en          (pc_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .if_id_misaligned (if_id_misaligned),
`endif
    .if_id_instr    (if_id_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Two time units past the rising edge: inputs are driven here, checks follow #1 later
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: got=valid entry expected=empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {63'd0, if_id_valid}, 64'd1);
      chk({tag, "_pc"},    {32'd0, if_id_pc},    {32'd0, e.pc});
      chk({tag, "_instr"}, {32'd0, if_id_instr}, {32'd0, e.instr});
`ifdef FETCH_MISALIGN_CHECK_EN
      chk({tag, "_mis"},   {63'd0, if_id_misaligned}, 64'd0);
`endif
      $display("txn %s pc=%08h instr=%08h", tag, if_id_pc, if_id_instr);
    end
  endtask

  // Cycle after accept: deliver the word, then check it lands in IF/ID
  task automatic respond(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = instr;
    e.pc = pc;
    e.instr = instr;
    sb.push_back(e);
    #1;
    chk("wait_no_req",  {63'd0, imem_req_valid}, 64'd0);
    chk("wait_no_pcen", {63'd0, pc_en},          64'd0);
    chk("bubble",       {63'd0, if_id_valid},    64'd0);
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    #1;
    pop_check("fetch");
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input int nwait);
    pc_in          = pc;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      #1;
      chk("hold_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("hold_req_addr",  {32'd0, imem_req_addr},  {32'd0, pc});
      chk("hold_no_pcen",   {63'd0, pc_en},          64'd0);
      step();
    end
    imem_req_ready = 1'b1;
    #1;
    chk("req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("req_addr",  {32'd0, imem_req_addr},  {32'd0, pc});
    chk("pc_en",     {63'd0, pc_en},          64'd1);
    respond(pc, instr);
  endtask

  initial begin
    rst = 1'b1;
    pc_in = 32'h1234;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    stall_in = 1'b0;
    flush_in = 1'b0;

    // Reset
    step();
    #1;
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_pc_en",     {63'd0, pc_en},          64'd0);
    step();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("rst_if_valid", {63'd0, if_id_valid}, 64'd0);
    chk("rst_if_pc",    {32'd0, if_id_pc},    64'd0);
    chk("rst_if_instr", {32'd0, if_id_instr}, 64'd0);
    chk("rst_req_after",{63'd0, imem_req_valid}, 64'd1);

    // Zero-wait streaming
    fetch(32'h0, 32'hA000_0001, 0);
    fetch(32'h4, 32'hA000_0002, 0);
    fetch(32'h8, 32'hA000_0003, 0);

    // Memory not ready for three cycles
    fetch(32'h10, 32'hB000_0010, 3);

    // Decode stall with response landing in the skid
    fetch(32'h20, 32'hC000_0020, 0);
    stall_in = 1'b1;
    pc_in = 32'h24;
    imem_req_ready = 1'b1;
    #1;
    chk("stall_pc_en", {63'd0, pc_en}, 64'd1);
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hC000_0024;
    sb.push_back('{pc: 32'h24, instr: 32'hC000_0024});
    #1;
    chk("stall_hold_pc", {32'd0, if_id_pc}, 64'h20);
    step();
    imem_rsp_valid = 1'b0;
    pc_in = 32'h28;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("skid_blocks_req", {63'd0, imem_req_valid}, 64'd0);
      chk("skid_no_pcen",    {63'd0, pc_en},          64'd0);
      chk("stall_hold_pc",   {32'd0, if_id_pc},       64'h20);
      chk("stall_hold_vld",  {63'd0, if_id_valid},    64'd1);
      step();
    end
    stall_in = 1'b0;
    #1;
    chk("skid_still_blocks", {63'd0, imem_req_valid}, 64'd0);
    step();
    #1;
    pop_check("skid_deliver");
    chk("after_skid_req",  {63'd0, imem_req_valid}, 64'd1);
    chk("after_skid_addr", {32'd0, imem_req_addr},  64'h28);
    chk("after_skid_pcen", {63'd0, pc_en},          64'd1);
    respond(32'h28, 32'hC000_0028);

    // Flush while a request is outstanding; late response must be dropped
    pc_in = 32'h30;
    imem_req_ready = 1'b1;
    #1;
    chk("fl_pc_en", {63'd0, pc_en}, 64'd1);
    step();
    imem_req_ready = 1'b0;
    flush_in = 1'b1;
    pc_in = 32'h100;
    #1;
    chk("fl_no_req", {63'd0, imem_req_valid}, 64'd0);
    step();
    flush_in = 1'b0;
    #1;
    chk("drop_no_req",  {63'd0, imem_req_valid}, 64'd0);
    chk("drop_no_pcen", {63'd0, pc_en},          64'd0);
    chk("drop_if_vld",  {63'd0, if_id_valid},    64'd0);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    chk("drop_rsp_no_req", {63'd0, imem_req_valid}, 64'd0);
    step();
    imem_rsp_valid = 1'b0;
    #1;
    chk("drop_discard",  {63'd0, if_id_valid},   64'd0);
    chk("redirect_req",  {63'd0, imem_req_valid}, 64'd1);
    chk("redirect_addr", {32'd0, imem_req_addr}, 64'h100);
    fetch(32'h100, 32'hD000_0100, 0);

    // Flush with a full skid and a coincident response
    stall_in = 1'b1;
    pc_in = 32'h104;
    imem_req_ready = 1'b1;
    #1;
    chk("fs_pc_en", {63'd0, pc_en}, 64'd1);
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hD000_0104;
    sb.push_back('{pc: 32'h104, instr: 32'hD000_0104});
    #1;
    step();
    imem_rsp_valid = 1'b0;
    #1;
    chk("fs_skid_full", {63'd0, imem_req_valid}, 64'd0);
    flush_in = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0BAD_0BAD;
    #1;
    chk("fs_flush_no_req", {63'd0, imem_req_valid}, 64'd0);
    step();
    flush_in = 1'b0;
    stall_in = 1'b0;
    imem_rsp_valid = 1'b0;
    sb.delete();
    #1;
    chk("fs_if_cleared", {63'd0, if_id_valid},    64'd0);
    chk("fs_req_next",   {63'd0, imem_req_valid}, 64'd1);
    step();
    #1;
    chk("fs_skid_cleared", {63'd0, if_id_valid}, 64'd0);

    // Flush coincident with the response in WAIT
    pc_in = 32'h200;
    imem_req_ready = 1'b1;
    #1;
    chk("fw_pc_en", {63'd0, pc_en}, 64'd1);
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0BAD_0200;
    flush_in = 1'b1;
    #1;
    chk("fw_no_req", {63'd0, imem_req_valid}, 64'd0);
    step();
    flush_in = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("fw_if_vld", {63'd0, if_id_valid},    64'd0);
    chk("fw_req",    {63'd0, imem_req_valid}, 64'd1);
    fetch(32'h204, 32'hE000_0204, 0);

    // Reset mid-fetch; a late response afterwards is ignored
    pc_in = 32'h300;
    imem_req_ready = 1'b1;
    #1;
    chk("rm_pc_en", {63'd0, pc_en}, 64'd1);
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0BAD_0300;
    #1;
    chk("rm_no_req", {63'd0, imem_req_valid}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rm_if_vld", {63'd0, if_id_valid},    64'd0);
    chk("rm_req",    {63'd0, imem_req_valid}, 64'd1);
    step();
    imem_rsp_valid = 1'b0;
    #1;
    chk("rm_late_ignored", {63'd0, if_id_valid}, 64'd0);

`ifdef FETCH_MISALIGN_CHECK_EN
    fetch(32'h400, 32'hF000_0400, 0);
    pc_in = 32'h42;
    imem_req_ready = 1'b1;
    #1;
    chk("mis_no_req",  {63'd0, imem_req_valid}, 64'd0);
    chk("mis_no_pcen", {63'd0, pc_en},          64'd0);
    step();
    #1;
    chk("mis_if_vld",   {63'd0, if_id_valid},      64'd1);
    chk("mis_if_pc",    {32'd0, if_id_pc},         64'h42);
    chk("mis_if_instr", {32'd0, if_id_instr},      64'd0);
    chk("mis_flag",     {63'd0, if_id_misaligned}, 64'd1);
    $display("txn misaligned pc=%08h", if_id_pc);
    pc_in = 32'h44;
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      chk("mis_stuck_req",  {63'd0, imem_req_valid}, 64'd0);
      chk("mis_stuck_pcen", {63'd0, pc_en},          64'd0);
    end
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    #1;
    chk("mis_release_req",  {63'd0, imem_req_valid}, 64'd1);
    chk("mis_release_pcen", {63'd0, pc_en},          64'd1);
    respond(32'h44, 32'hF000_0044);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
